// File: rtl/slowdiv_absval.sv
// slowdiv_absval
//   Combinational magnitude/sign extraction for one divider operand.
//   The magnitude is one bit wider than the operand so that the
//   most-negative two's-complement value (-2^(W-1)) has a representable
//   magnitude (2^(W-1)).
//
// Ports:
//   i_v    in  W    operand (two's complement when OPT_SIGNED=1)
//   o_mag  out W+1  |i_v| (raw zero-extended value when OPT_SIGNED=0)
//   o_neg  out 1    operand is negative (always 0 when OPT_SIGNED=0)
module slowdiv_absval #(
  parameter int   W          = 18,
  parameter logic OPT_SIGNED = 1'b1
) (
  input  logic [W-1:0] i_v,
  output logic [W:0]   o_mag,
  output logic         o_neg
);

  logic [W:0] ext;

  always_comb begin
    o_neg = OPT_SIGNED & i_v[W-1];
    ext   = {o_neg, i_v};
    // Negating in W+1 bits: -(-2^(W-1)) stays positive instead of wrapping.
    o_mag = o_neg ? (~ext + 1'b1) : ext;
  end

endmodule

// File: rtl/slowdiv.sv
// slowdiv
//   Sequential restoring (shift-subtract) divider producing one quotient
//   bit per clock, signed or unsigned. Latency is fixed: o_busy is high for
//   exactly NA+1 cycles after acceptance and o_done rises NA+1 edges after
//   the accepting edge. Uses the same strobe/busy/done/aux handshake as the
//   slow shift-add multiplier.
//
// Ports:
//   i_clk    in   1   clock
//   i_reset  in   1   synchronous, active-high reset; aborts any operation
//   i_stb    in   1   start request, accepted only while o_busy=0
//   i_n      in   NA  dividend
//   i_d      in   NB  divisor
//   i_aux    in   1   sideband bit carried with the operation
//   o_busy   out  1   operation in progress
//   o_done   out  1   result valid, held until the next accepted i_stb
//   o_q      out  NA  quotient (truncated toward zero when signed)
//   o_r      out  NB  remainder (sign of the dividend when signed)
//   o_err    out  1   divide-by-zero or signed overflow
//   o_aux    out  1   i_aux captured at acceptance
module slowdiv #(
  parameter int   LGNA       = 5,
  parameter int   NA         = 18,
  parameter int   NB         = 18,
  parameter logic OPT_SIGNED = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_stb,
  input  logic [NA-1:0] i_n,
  input  logic [NB-1:0] i_d,
  input  logic          i_aux,
  output logic          o_busy,
  output logic          o_done,
  output logic [NA-1:0] o_q,
  output logic [NB-1:0] o_r,
  output logic          o_err,
  output logic          o_aux
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [NA-1:0]   MIN_N      = {1'b1, {(NA-1){1'b0}}};
  localparam logic [LGNA-1:0] COUNT_LOAD = LGNA'(NA - 1);

  logic [1:0]      state;
  logic [LGNA-1:0] count;
  logic [NA:0]     n_mag;     // dividend magnitude, consumed MSB first
  logic [NB:0]     d_mag;     // divisor magnitude
  logic [NB:0]     rem;       // partial remainder
  logic [NA-1:0]   q_sh;      // quotient magnitude, built LSB-in
  logic            q_neg;
  logic            r_neg;
  logic            aux_r;
  logic            div_zero;
  logic            ovf;

  // Operand magnitude/sign capture.
  logic [NA:0] abs_n;
  logic [NB:0] abs_d;
  logic        neg_n;
  logic        neg_d;

  slowdiv_absval #(.W(NA), .OPT_SIGNED(OPT_SIGNED)) u_abs_n (
    .i_v   (i_n),
    .o_mag (abs_n),
    .o_neg (neg_n)
  );

  slowdiv_absval #(.W(NB), .OPT_SIGNED(OPT_SIGNED)) u_abs_d (
    .i_v   (i_d),
    .o_mag (abs_d),
    .o_neg (neg_d)
  );

  logic in_zero;
  logic in_ovf;

  always_comb begin
    in_zero = (i_d == '0);
    in_ovf  = OPT_SIGNED & (i_n == MIN_N) & (i_d == '1);
  end

  // Conditional-subtract step. rem < |d| holds between iterations, so the
  // shifted trial fits in NB+1 bits; the wider copy only feeds the compare.
  logic          next_bit;
  logic [NB+1:0] trial_wide;
  logic [NB:0]   trial;
  logic          take;
  logic [NB:0]   rem_next;

  always_comb begin
    next_bit   = n_mag[NA-1];
    trial_wide = {rem, next_bit};
    trial      = {rem[NB-1:0], next_bit};
    take       = (trial_wide >= {1'b0, d_mag});
    rem_next   = take ? (trial - d_mag) : trial;
  end

  // n_mag[NA] is only ever set for values outside the NA-bit operand range.
  logic unused_n_top;
  assign unused_n_top = n_mag[NA];

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_IDLE;
      count    <= '0;
      n_mag    <= '0;
      d_mag    <= '0;
      rem      <= '0;
      q_sh     <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      aux_r    <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_q      <= '0;
      o_r      <= '0;
      o_err    <= 1'b0;
      o_aux    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_stb && !o_busy) begin
            state    <= S_RUN;
            o_busy   <= 1'b1;
            o_done   <= 1'b0;
            count    <= COUNT_LOAD;
            n_mag    <= abs_n;
            d_mag    <= abs_d;
            rem      <= '0;
            q_sh     <= '0;
            q_neg    <= neg_n ^ neg_d;
            r_neg    <= neg_n;
            aux_r    <= i_aux;
            div_zero <= in_zero;
            ovf      <= in_ovf;
          end
        end

        S_RUN: begin
          n_mag <= {n_mag[NA-1:0], 1'b0};
          rem   <= rem_next;
          q_sh  <= {q_sh[NA-2:0], take};
          count <= count - 1'b1;
          if (count == '0)
            state <= S_FIX;
        end

        S_FIX: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b1;
          o_aux  <= aux_r;
          if (div_zero) begin
            o_q   <= '1;
            o_r   <= '0;
            o_err <= 1'b1;
          end else if (ovf) begin
            o_q   <= MIN_N;
            o_r   <= '0;
            o_err <= 1'b1;
          end else begin
            o_q   <= q_neg ? (~q_sh + 1'b1) : q_sh;
            o_r   <= r_neg ? (~rem[NB-1:0] + 1'b1) : rem[NB-1:0];
            o_err <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slowdiv.sv
// tb_slowdiv
//   Self-checking bench for slowdiv with NA=NB=8, LGNA=4. An unsigned and a
//   signed instance share the same stimulus; each is compared against an
//   integer-arithmetic reference model, plus directed constant checks.
module tb_slowdiv;

  localparam int N = 8;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_stb = 1'b0;
  logic [N-1:0] i_n = '0;
  logic [N-1:0] i_d = '0;
  logic         i_aux = 1'b0;

  logic         busy_u, done_u, err_u, aux_u;
  logic [N-1:0] q_u, r_u;
  logic         busy_s, done_s, err_s, aux_s;
  logic [N-1:0] q_s, r_s;

  slowdiv #(.LGNA(4), .NA(N), .NB(N), .OPT_SIGNED(1'b0)) u_uns (
    .i_clk(i_clk), .i_reset(i_reset), .i_stb(i_stb), .i_n(i_n), .i_d(i_d),
    .i_aux(i_aux), .o_busy(busy_u), .o_done(done_u), .o_q(q_u), .o_r(r_u),
    .o_err(err_u), .o_aux(aux_u)
  );

  slowdiv #(.LGNA(4), .NA(N), .NB(N), .OPT_SIGNED(1'b1)) u_sgn (
    .i_clk(i_clk), .i_reset(i_reset), .i_stb(i_stb), .i_n(i_n), .i_d(i_d),
    .i_aux(i_aux), .o_busy(busy_s), .o_done(done_s), .o_q(q_s), .o_r(r_s),
    .o_err(err_s), .o_aux(aux_s)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer division (SV truncates toward zero and gives
  // the remainder the dividend's sign), plus the two error cases.
  function automatic void ref_div(input logic [N-1:0] n, input logic [N-1:0] d,
                                  input bit sgn, output logic [N-1:0] q,
                                  output logic [N-1:0] r, output logic err);
    int nv, dv, qi, ri;
    if (sgn) begin
      nv = int'($signed(n));
      dv = int'($signed(d));
    end else begin
      nv = int'(n);
      dv = int'(d);
    end
    if (dv == 0) begin
      q = '1; r = '0; err = 1'b1;
    end else if (sgn && nv == -128 && dv == -1) begin
      q = 8'h80; r = '0; err = 1'b1;
    end else begin
      qi = nv / dv;
      ri = nv % dv;
      q = qi[N-1:0]; r = ri[N-1:0]; err = 1'b0;
    end
  endfunction

  // Results expected to be visible on the outputs before the next FIX.
  logic [N-1:0] pq_u = '0, pr_u = '0, pq_s = '0, pr_s = '0;
  logic         pe_u = 1'b0, pe_s = 1'b0, pa = 1'b0;

  // Runs one operation on both instances. Called at posedge+#1. When
  // ignore_at > 0, a second strobe with other operands is pulsed at that
  // cycle of the run and must have no effect.
  task automatic do_op(input logic [N-1:0] n, input logic [N-1:0] d,
                       input logic aux, input int ignore_at);
    logic [N-1:0] eq, er;
    logic         ee;
    int cyc, lat_u, lat_s, bz_u, bz_s;
    i_n = n; i_d = d; i_aux = aux; i_stb = 1'b1;
    @(posedge i_clk); #1;
    i_stb = 1'b0;
    i_n = $urandom; i_d = $urandom; i_aux = $urandom;
    check("busy_u_after_accept", busy_u, 1'b1);
    check("busy_s_after_accept", busy_s, 1'b1);
    check("done_u_dropped", done_u, 1'b0);
    check("done_s_dropped", done_s, 1'b0);
    check("held_q_u", q_u, pq_u);
    check("held_q_s", q_s, pq_s);
    check("held_r_s", r_s, pr_s);
    check("held_err_s", err_s, pe_s);
    check("held_aux_s", aux_s, pa);
    cyc = 0; lat_u = 0; lat_s = 0; bz_u = 1; bz_s = 1;
    while ((lat_u == 0 || lat_s == 0) && cyc < 20) begin
      if (ignore_at > 0 && cyc == ignore_at) begin
        i_n = 8'd99; i_d = 8'd9; i_stb = 1'b1;
      end
      @(posedge i_clk); #1;
      i_stb = 1'b0;
      cyc++;
      if (busy_u) bz_u++;
      if (busy_s) bz_s++;
      if (done_u && lat_u == 0) lat_u = cyc;
      if (done_s && lat_s == 0) lat_s = cyc;
    end
    check("latency_u", lat_u, N + 1);
    check("latency_s", lat_s, N + 1);
    check("busy_cycles_u", bz_u, N + 1);
    check("busy_cycles_s", bz_s, N + 1);
    ref_div(n, d, 1'b0, eq, er, ee);
    check("q_u", q_u, eq); check("r_u", r_u, er); check("err_u", err_u, ee);
    pq_u = eq; pr_u = er; pe_u = ee;
    ref_div(n, d, 1'b1, eq, er, ee);
    check("q_s", q_s, eq); check("r_s", r_s, er); check("err_s", err_s, ee);
    pq_s = eq; pr_s = er; pe_s = ee;
    check("aux_u", aux_u, aux); check("aux_s", aux_s, aux);
    pa = aux;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {busy_u, busy_s}, 2'b00);
    check({tag, "_done"}, {done_u, done_s}, 2'b00);
    check({tag, "_err"},  {err_u, err_s},   2'b00);
    check({tag, "_aux"},  {aux_u, aux_s},   2'b00);
    check({tag, "_q"},    {q_u, q_s},       16'h0);
    check({tag, "_r"},    {r_u, r_s},       16'h0);
  endtask

  initial begin
    logic [N-1:0] rn, rd;
    int seen_done;

    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    check_all_zero("reset");

    // Directed cases from the test plan.
    do_op(8'd200, 8'd7, 1'b1, 0);
    check("dir_200_7_q_u", q_u, 8'd28);
    check("dir_200_7_r_u", r_u, 8'd4);
    check("dir_200_7_err_u", err_u, 1'b0);
    check("dir_200_7_aux_u", aux_u, 1'b1);

    do_op(8'h9C, 8'd7, 1'b0, 0);            // -100 / 7
    check("dir_m100_7_q_s", q_s, 8'hF2);
    check("dir_m100_7_r_s", r_s, 8'hFE);

    do_op(8'd100, 8'hF9, 1'b1, 0);          // 100 / -7
    check("dir_100_m7_q_s", q_s, 8'hF2);
    check("dir_100_m7_r_s", r_s, 8'h02);

    do_op(8'h80, 8'd3, 1'b0, 0);            // -128 / 3
    check("dir_m128_3_q_s", q_s, 8'hD6);
    check("dir_m128_3_r_s", r_s, 8'hFE);

    do_op(8'h80, 8'hFF, 1'b1, 0);           // signed overflow
    check("dir_ovf_err_s", err_s, 1'b1);
    check("dir_ovf_q_s", q_s, 8'h80);
    check("dir_ovf_r_s", r_s, 8'h00);

    do_op(8'd5, 8'd0, 1'b0, 0);             // divide by zero
    check("dir_dz_err", {err_u, err_s}, 2'b11);
    check("dir_dz_q", {q_u, q_s}, 16'hFFFF);
    check("dir_dz_r", {r_u, r_s}, 16'h0000);

    do_op(8'd9, 8'd3, 1'b1, 0);
    check("dir_9_3_q", {q_u, q_s}, {8'd3, 8'd3});
    check("dir_9_3_r", {r_u, r_s}, 16'h0000);
    check("dir_9_3_err", {err_u, err_s}, 2'b00);

    // Strobe while busy must be ignored.
    do_op(8'd50, 8'd5, 1'b0, 3);
    check("busy_ign_q", {q_u, q_s}, {8'd10, 8'd10});
    check("busy_ign_r", {r_u, r_s}, 16'h0000);

    // Reset in the middle of an operation aborts it.
    i_n = 8'd77; i_d = 8'd4; i_aux = 1'b1; i_stb = 1'b1;
    @(posedge i_clk); #1;
    i_stb = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    check_all_zero("abort");
    seen_done = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge i_clk); #1;
      if (done_u || done_s || busy_u || busy_s) seen_done++;
    end
    check("abort_no_done", seen_done, 0);
    pq_u = '0; pr_u = '0; pe_u = 1'b0; pq_s = '0; pr_s = '0; pe_s = 1'b0; pa = 1'b0;
    do_op(8'd77, 8'd4, 1'b1, 0);
    check("after_abort_q_u", q_u, 8'd19);

    // Random sweep, biased toward the corner operands.
    for (int i = 0; i < 3500; i++) begin
      rn = $urandom;
      rd = $urandom;
      case ($urandom_range(0, 9))
        0: rd = 8'h00;
        1: rd = 8'hFF;
        2: rn = 8'h80;
        3: begin rn = 8'h80; rd = 8'hFF; end
        4: rd = 8'($urandom_range(1, 3));
        default: ;
      endcase
      do_op(rn, rd, 1'($urandom), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
